// File: rtl/do_while_loop_pkg.sv
// -----------------------------------------------------------------------------
// do_while_loop_pkg
//   Shared definitions for the nested do-while loop controller.
//   - loop_state_e : controller FSM states
//   - lvl_width()  : width of a counter that holds 0..depth frames
//
//   The frame record {limit, iter} depends on the CNT_W parameter of the
//   instantiating module. SV-2012 packages cannot take parameters, so each
//   module declares frame_t locally from its own CNT_W. The stack stores
//   frames as flat 2*CNT_W-bit words, laid out as {limit, iter}.
// -----------------------------------------------------------------------------
package do_while_loop_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,   // no active frame
      RUN   = 2'd1,   // innermost body requested or in progress
      CHECK = 2'd2    // body finished, evaluating iter+1 < limit
   } loop_state_e;

   // Bits needed to count 0..depth active frames. A depth below 1 is
   // clamped so a bad parameter cannot produce a zero-width vector.
   function automatic int lvl_width(input int depth);
      return (depth < 1) ? 1 : $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/do_while_loop_ctrl_stack.sv
// -----------------------------------------------------------------------------
// loop_frame_stack
//   DEPTH-entry LIFO of saved loop frames. A frame is a flat word laid out
//   as {limit, iter}.
//
//   Ports
//     clk    in   clock
//     rst    in   synchronous active-high reset; empties the stack and
//                 clears every entry
//     push   in   write din on top; ignored when full
//     pop    in   drop the top entry; ignored when empty or while pushing
//     din    in   frame to save
//     top    out  most recently saved frame; zero when empty
//     count  out  registered occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module loop_frame_stack
   import do_while_loop_pkg::*;
#(
   parameter int CNT_W = 8,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic                          pop,
   input  logic [2*CNT_W-1:0]            din,
   output logic [2*CNT_W-1:0]            top,
   output logic [lvl_width(DEPTH)-1:0]   count
);

   localparam int LVL_W = lvl_width(DEPTH);
   // A single-entry stack still needs a one-bit index.
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [2*CNT_W-1:0] mem [DEPTH];
   logic [LVL_W-1:0]   cnt_q;
   logic [LVL_W-1:0]   cnt_m1;
   logic [IDX_W-1:0]   wr_idx;
   logic [IDX_W-1:0]   rd_idx;
   logic               full;
   logic               empty;

   assign full   = (cnt_q == LVL_W'(DEPTH));
   assign empty  = (cnt_q == '0);
   assign cnt_m1 = cnt_q - LVL_W'(1);
   assign wr_idx = cnt_q[IDX_W-1:0];
   assign rd_idx = cnt_m1[IDX_W-1:0];

   // With an empty stack rd_idx wraps, so mask the read to a clean zero.
   assign top   = empty ? '0 : mem[rd_idx];
   assign count = cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push && !full) begin
         mem[wr_idx] <= din;
         cnt_q       <= cnt_q + LVL_W'(1);
      end else if (pop && !empty) begin
         cnt_q <= cnt_m1;
      end
   end

endmodule

// File: rtl/do_while_loop_ctrl.sv
// -----------------------------------------------------------------------------
// do_while_loop_ctrl
//   Nested do-while loop controller. Every push opens a new innermost frame
//   with its own iteration counter. The enclosing frame is parked on a LIFO
//   and comes back unchanged when the inner frame pops. Each body runs at
//   least once, and the condition iter+1 < limit is tested after every
//   completed body.
//
//   Ports
//     clk         in   clock
//     rst         in   synchronous active-high reset
//     push_valid  in   open a new innermost loop
//     push_limit  in   limit of the loop being opened
//     push_ready  out  push accepted this cycle (IDLE/RUN and not full)
//     body_valid  out  innermost frame requests/holds a body iteration
//     body_ready  in   body executor finished the current iteration
//     brk         in   terminate innermost frame (honoured only in RUN)
//     iter        out  innermost iteration index, 0 when idle
//     level       out  number of active frames
//     loop_exit   out  one-cycle pulse on every frame pop
//     overflow    out  sticky: push attempted with all frames in use
// -----------------------------------------------------------------------------
module do_while_loop_ctrl
   import do_while_loop_pkg::*;
#(
   parameter int CNT_W = 8,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push_valid,
   input  logic [CNT_W-1:0]              push_limit,
   output logic                          push_ready,
   output logic                          body_valid,
   input  logic                          body_ready,
   input  logic                          brk,
   output logic [CNT_W-1:0]              iter,
   output logic [lvl_width(DEPTH)-1:0]   level,
   output logic                          loop_exit,
   output logic                          overflow
);

   localparam int LVL_W = lvl_width(DEPTH);

   typedef struct packed {
      logic [CNT_W-1:0] limit;
      logic [CNT_W-1:0] iter;
   } frame_t;

   loop_state_e        state_q, state_d;
   frame_t             cur_q, cur_d;      // live innermost frame
   logic               exit_q, exit_d;
   logic               ovf_q, ovf_d;

   logic               stk_push, stk_pop;
   logic [2*CNT_W-1:0] stk_top;
   logic [LVL_W-1:0]   stk_count;

   logic               at_full;
   logic               push_ok;
   logic               do_pop;
   logic [CNT_W:0]     nxt;               // one extra bit so limit 2^CNT_W-1 never wraps

   // Every accepted push parks the current frame, including the all-zero
   // idle frame at level 0. Stack occupancy therefore equals the nesting
   // level, and popping the last frame restores iter = 0 automatically.
   loop_frame_stack #(
      .CNT_W (CNT_W),
      .DEPTH (DEPTH)
   ) u_stack (
      .clk   (clk),
      .rst   (rst),
      .push  (stk_push),
      .pop   (stk_pop),
      .din   (cur_q),
      .top   (stk_top),
      .count (stk_count)
   );

   assign level      = stk_count;
   assign at_full    = (stk_count == LVL_W'(DEPTH));
   assign push_ready = (state_q != CHECK) && !at_full;
   assign push_ok    = push_valid && push_ready;
   assign body_valid = (state_q == RUN);
   assign iter       = cur_q.iter;
   assign loop_exit  = exit_q;
   assign overflow   = ovf_q;
   assign nxt        = {1'b0, cur_q.iter} + (CNT_W+1)'(1);

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d  = state_q;
      cur_d    = cur_q;
      stk_push = 1'b0;
      stk_pop  = 1'b0;
      exit_d   = 1'b0;
      do_pop   = 1'b0;
      // A dropped push leaves the rest of the state untouched.
      ovf_d    = ovf_q | (push_valid & at_full);

      case (state_q)
         IDLE: begin
            if (push_ok) begin
               stk_push    = 1'b1;
               cur_d.limit = push_limit;
               cur_d.iter  = '0;
               state_d     = RUN;
            end
         end

         // Priority is brk > push > body handshake. A losing request is not
         // consumed and stays pending for as long as its owner holds it.
         RUN: begin
            if (brk) begin
               do_pop = 1'b1;
            end else if (push_ok) begin
               // The body is opening an inner loop. The outer body stays
               // in progress and resumes after the inner frame pops.
               stk_push    = 1'b1;
               cur_d.limit = push_limit;
               cur_d.iter  = '0;
               state_d     = RUN;
            end else if (body_ready) begin
               state_d = CHECK;
            end
         end

         CHECK: begin
            if (nxt < {1'b0, cur_q.limit}) begin
               cur_d.iter = nxt[CNT_W-1:0];
               state_d    = RUN;
            end else begin
               do_pop = 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase

      // A pop returns to the parked outer frame. If one exists, its body was
      // in progress when the inner loop opened, so control goes straight
      // back to RUN.
      if (do_pop) begin
         stk_pop = 1'b1;
         exit_d  = 1'b1;
         cur_d   = frame_t'(stk_top);
         state_d = (stk_count > LVL_W'(1)) ? RUN : IDLE;
      end
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cur_q   <= '0;
         exit_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         exit_q  <= exit_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_do_while_loop_ctrl.sv
// -----------------------------------------------------------------------------
// tb_do_while_loop_ctrl
//   Directed scenarios followed by a random phase. A frame-stack reference
//   model built on queues tracks the expected outputs, and every output is
//   compared after each clock edge.
// -----------------------------------------------------------------------------
module tb_do_while_loop_ctrl;

   localparam int CNT_W = 8;
   localparam int DEPTH = 4;
   localparam int LVL_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             push_valid;
   logic [CNT_W-1:0] push_limit;
   logic             push_ready;
   logic             body_valid;
   logic             body_ready;
   logic             brk;
   logic [CNT_W-1:0] iter;
   logic [LVL_W-1:0] level;
   logic             loop_exit;
   logic             overflow;

   always #5 clk = ~clk;

   do_while_loop_ctrl #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .push_valid (push_valid),
      .push_limit (push_limit),
      .push_ready (push_ready),
      .body_valid (body_valid),
      .body_ready (body_ready),
      .brk        (brk),
      .iter       (iter),
      .level      (level),
      .loop_exit  (loop_exit),
      .overflow   (overflow)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: one queue entry per open loop. m_done marks that the
   // innermost body has completed and its condition is due next cycle.
   int m_lim[$];
   int m_it[$];
   bit m_done = 0;
   bit m_ovf  = 0;
   bit m_exit = 0;

   int hs[$];        // iter value of each observed body handshake
   int exits = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic m_push(input int lim);
      m_lim.push_back(lim);
      m_it.push_back(0);
   endtask

   task automatic m_pop();
      void'(m_lim.pop_back());
      void'(m_it.pop_back());
      m_exit = 1;
   endtask

   // One clock: record the handshake, advance the model with the applied
   // inputs, then compare every output 1 time unit after the edge.
   task automatic step();
      int n;
      bit acc_push;
      acc_push = push_valid && push_ready;
      if (!rst && body_valid && body_ready && !brk && !acc_push)
         hs.push_back(int'(iter));
      @(posedge clk);
      m_exit = 0;
      n = m_lim.size();
      if (rst) begin
         m_lim.delete();
         m_it.delete();
         m_done = 0;
         m_ovf  = 0;
      end else begin
         if (push_valid && n == DEPTH) m_ovf = 1;
         if (n == 0) begin
            if (push_valid) m_push(int'(push_limit));
         end else if (m_done) begin
            m_done = 0;
            if (m_it[n-1] + 1 < m_lim[n-1]) m_it[n-1] = m_it[n-1] + 1;
            else m_pop();
         end else if (brk) begin
            m_pop();
         end else if (push_valid && n < DEPTH) begin
            m_push(int'(push_limit));
         end else if (body_ready) begin
            m_done = 1;
         end
      end
      #1;
      if (loop_exit) exits++;
      n = m_lim.size();
      chk("level",      32'(level),      32'(n));
      chk("iter",       32'(iter),       (n > 0) ? 32'(m_it[n-1]) : 32'd0);
      chk("body_valid", 32'(body_valid), 32'((n > 0) && !m_done));
      chk("push_ready", 32'(push_ready), 32'(!m_done && (n < DEPTH)));
      chk("loop_exit",  32'(loop_exit),  32'(m_exit));
      chk("overflow",   32'(overflow),   32'(m_ovf));
   endtask

   task automatic run_until_exit(input int bound, input string tag);
      bit seen;
      seen = 0;
      for (int k = 0; k < bound && !seen; k++) begin
         step();
         if (loop_exit) seen = 1;
      end
      chk({tag, "_exit_seen"}, 32'(seen), 32'd1);
   endtask

   task automatic idle_inputs();
      push_valid = 0; push_limit = '0; body_ready = 0; brk = 0; rst = 0;
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      step();
      step();
      rst = 0;
      step();

      // Single loop, limit 3
      hs.delete(); exits = 0;
      push_valid = 1; push_limit = 8'd3; step();
      push_valid = 0; body_ready = 1;
      run_until_exit(20, "single");
      body_ready = 0; step();
      chk("single_bodies", 32'(hs.size()), 32'd3);
      for (int i = 0; i < 3 && i < hs.size(); i++) chk("single_iter", 32'(hs[i]), 32'(i));
      chk("single_exits", 32'(exits), 32'd1);
      chk("single_level", 32'(level), 32'd0);

      // Do-while minimum: limit 0 and limit 1 each run one body
      for (int l = 0; l < 2; l++) begin
         hs.delete(); exits = 0;
         push_valid = 1; push_limit = CNT_W'(l); step();
         push_valid = 0; body_ready = 1;
         run_until_exit(10, "min");
         body_ready = 0; step(); step();
         chk("min_bodies", 32'(hs.size()), 32'd1);
         chk("min_exits",  32'(exits),     32'd1);
      end

      // Nesting with scope restore
      push_valid = 1; push_limit = 8'd2; step();
      push_valid = 0; body_ready = 1; step();   // outer body iter 0
      body_ready = 0; step();                   // CHECK -> RUN iter 1
      chk("nest_outer_iter", 32'(iter), 32'd1);
      push_valid = 1; push_limit = 8'd3; step();
      push_valid = 0;
      chk("nest_level2", 32'(level), 32'd2);
      chk("nest_inner_iter0", 32'(iter), 32'd0);
      hs.delete(); exits = 0;
      body_ready = 1;
      run_until_exit(20, "nest_inner");
      chk("nest_inner_bodies", 32'(hs.size()), 32'd3);
      for (int i = 0; i < 3 && i < hs.size(); i++) chk("nest_inner_iter", 32'(hs[i]), 32'(i));
      chk("nest_restored_iter", 32'(iter),       32'd1);
      chk("nest_restored_bv",   32'(body_valid), 32'd1);
      chk("nest_restored_lvl",  32'(level),      32'd1);
      hs.delete();
      step();                                   // outer handshake iter 1
      body_ready = 0; step();                   // CHECK pops outer
      chk("nest_outer_last", 32'(hs.size()), 32'd1);
      chk("nest_outer_exit", 32'(loop_exit),  32'd1);
      chk("nest_done_level", 32'(level),      32'd0);

      // Overflow at DEPTH = 4
      push_valid = 1; push_limit = 8'd10;
      for (int i = 0; i < DEPTH; i++) step();
      chk("ovf_push_ready", 32'(push_ready), 32'd0);
      step();
      chk("ovf_flag",  32'(overflow), 32'd1);
      chk("ovf_level", 32'(level),    32'd4);
      push_valid = 0; step(); step();
      chk("ovf_sticky", 32'(overflow), 32'd1);

      // Reset while in CHECK at level 3
      brk = 1; step();
      brk = 0; body_ready = 1; step();
      body_ready = 0;
      chk("rst_pre_level", 32'(level), 32'd3);
      rst = 1; step();
      rst = 0;
      chk("rst_level", 32'(level),      32'd0);
      chk("rst_iter",  32'(iter),       32'd0);
      chk("rst_bv",    32'(body_valid), 32'd0);
      chk("rst_ovf",   32'(overflow),   32'd0);

      // brk beats push and body handshake in the same RUN cycle
      push_valid = 1; push_limit = 8'd5; step();
      brk = 1; body_ready = 1; push_valid = 1; push_limit = 8'd7; step();
      idle_inputs();
      chk("prio_exit",  32'(loop_exit), 32'd1);
      chk("prio_level", 32'(level),     32'd0);
      step();

      // Limit 255 runs 255 bodies with no wrap
      hs.delete(); exits = 0;
      push_valid = 1; push_limit = 8'd255; step();
      push_valid = 0; body_ready = 1;
      run_until_exit(600, "lim255");
      body_ready = 0; step();
      chk("lim255_bodies", 32'(hs.size()), 32'd255);
      if (hs.size() == 255) chk("lim255_last_iter", 32'(hs[254]), 32'd254);
      chk("lim255_exits", 32'(exits), 32'd1);

      // Random phase
      for (int c = 0; c < 3000; c++) begin
         push_valid = ($urandom_range(0, 5) == 0);
         push_limit = CNT_W'($urandom_range(0, 5));
         body_ready = $urandom_range(0, 1) == 1;
         brk        = ($urandom_range(0, 15) == 0);
         rst        = ($urandom_range(0, 299) == 0);
         step();
      end
      idle_inputs();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
